// File: rtl/fir_tap_feeder.sv
// rtl/fir_tap_feeder.sv - 64-entry sample history streamed newest-first, one tap per clock
module fir_tap_feeder #(
    parameter int TAPS      = 64,
    parameter int ADDR_BITS = 6,
    parameter int WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [WIDTH-1:0]     x,
    output logic [ADDR_BITS-1:0] tap_idx,
    output logic                 x_valid,
    output logic                 frame_start,
    output logic                 frame_last,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [ADDR_BITS-1:0] K_LAST = ADDR_BITS'(TAPS - 1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] k_q, k_d;
    logic [ADDR_BITS-1:0] wptr_q, base_q;
    logic [WIDTH-1:0]     mem_q [TAPS];
    logic [WIDTH-1:0]     x_q;
    logic [ADDR_BITS-1:0] tap_idx_q;
    logic                 x_valid_q, frame_start_q, frame_last_q, overrun_q;

    logic                 k_last;
    logic                 accept;
    logic [ADDR_BITS-1:0] rd_addr;

    assign k_last    = (k_q == K_LAST);
    assign din_ready = (state_q == IDLE) || ((state_q == STREAM) && k_last);
    assign accept    = din_valid && din_ready;
    // Natural ADDR_BITS wrap gives the modulo-TAPS walk back through history.
    assign rd_addr   = base_q - k_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = STREAM;
                    k_d     = '0;
                end
            end
            STREAM: begin
                if (k_last) begin
                    if (accept) begin
                        k_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    k_d = k_q + ADDR_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The tap read and the history write share an edge; non-blocking update
    // makes a back-to-back frame's final tap see the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            wptr_q        <= '0;
            base_q        <= '0;
            x_q           <= '0;
            tap_idx_q     <= '0;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                mem_q[wptr_q] <= din;
                base_q        <= wptr_q;
                wptr_q        <= wptr_q + ADDR_BITS'(1);
            end
            if (din_valid && !din_ready) begin
                overrun_q <= 1'b1;
            end
            if (state_q == STREAM) begin
                x_q           <= mem_q[rd_addr];
                tap_idx_q     <= k_q;
                x_valid_q     <= 1'b1;
                frame_start_q <= (k_q == '0);
                frame_last_q  <= k_last;
            end else begin
                x_valid_q     <= 1'b0;
                frame_start_q <= 1'b0;
                frame_last_q  <= 1'b0;
            end
        end
    end

    assign x           = x_q;
    assign tap_idx     = tap_idx_q;
    assign x_valid     = x_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
    assign busy        = (state_q == STREAM);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fir_tap_feeder.sv
// tb/tb_fir_tap_feeder.sv - randomized self-checking bench for fir_tap_feeder
module tb_fir_tap_feeder;

    localparam int TAPS = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] x;
    logic [5:0]  tap_idx;
    logic        x_valid, frame_start, frame_last, busy, overrun;

    int checks = 0;
    int errors = 0;

    fir_tap_feeder dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .x(x), .tap_idx(tap_idx), .x_valid(x_valid), .frame_start(frame_start),
        .frame_last(frame_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference: list of every accepted sample plus the edge index of the latest accept.
    logic [15:0] hist[$];
    int          cyc, a_cyc, a_n;
    bit          have_acc, m_ready, m_busy, m_over;
    bit          e_valid, e_fs, e_fl;
    logic [5:0]  e_tap;
    logic [15:0] e_x;

    task automatic model_clear();
        hist.delete();
        cyc = 0; a_cyc = 0; a_n = 0;
        have_acc = 0; m_ready = 1; m_busy = 0; m_over = 0;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // One clock: drive at negedge, advance model, return at the next negedge.
    task automatic tick(input bit v, input logic [15:0] d);
        bit acc;
        int t;
        din_valid = v;
        din = d;
        acc = v && m_ready;
        if (v && !m_ready) m_over = 1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        e_valid = 0; e_fs = 0; e_fl = 0; e_tap = '0; e_x = '0;
        if (have_acc) begin
            t = cyc - a_cyc - 1;
            if (t >= 0 && t < TAPS) begin
                e_valid = 1;
                e_tap = 6'(t);
                e_x = (a_n > t) ? hist[a_n - 1 - t] : 16'h0000;
                e_fs = (t == 0);
                e_fl = (t == TAPS - 1);
            end
        end
        if (acc) begin
            hist.push_back(d);
            a_cyc = cyc;
            a_n = hist.size();
            have_acc = 1;
        end
        t = have_acc ? (cyc - a_cyc) : 1000;
        m_busy = (t <= TAPS - 1);
        m_ready = !(t <= TAPS - 2);
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({x_valid, frame_start, frame_last, overrun, busy} !== 5'b0 || x !== 16'h0 || tap_idx !== 6'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b fs=%b fl=%b ov=%b busy=%b x=%h tap=%0d exp all zero",
                     x_valid, frame_start, frame_last, overrun, busy, x, tap_idx);
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", din_ready);
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_single();
        int nvalid = 0;
        do_reset();
        tick(1'b1, 16'h1234);
        for (int i = 0; i < TAPS + 3; i++) begin
            if (i > 0) tick(1'b0, 16'h0);
            if (x_valid === 1'b1) nvalid++;
            checks++;
            if ({x_valid, frame_start, frame_last} !== {e_valid, e_fs, e_fl} || (e_valid && {tap_idx, x} !== {e_tap, e_x})) begin
                errors++;
                $display("FAIL single_stream cyc=%0d got v=%b tap=%0d x=%h fs=%b fl=%b exp v=%b tap=%0d x=%h fs=%b fl=%b",
                         cyc, x_valid, tap_idx, x, frame_start, frame_last, e_valid, e_tap, e_x, e_fs, e_fl);
            end
            checks++;
            if ({din_ready, busy, overrun} !== {m_ready, m_busy, m_over}) begin
                errors++;
                $display("FAIL single_ctrl cyc=%0d got rdy=%b busy=%b ov=%b exp rdy=%b busy=%b ov=%b",
                         cyc, din_ready, busy, overrun, m_ready, m_busy, m_over);
            end
            if (i == 1) begin
                checks++;
                if (x_valid !== 1'b1 || x !== 16'h1234 || frame_start !== 1'b1) begin
                    errors++;
                    $display("FAIL single_tap0 got v=%b x=%h fs=%b exp v=1 x=1234 fs=1", x_valid, x, frame_start);
                end
            end
        end
        checks++;
        if (nvalid != TAPS) begin
            errors++;
            $display("FAIL single_valid_len got %0d exp %0d", nvalid, TAPS);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] last63 = 16'hDEAD;
        int budget = 0;
        do_reset();
        while (hist.size() < 65 && budget < 65 * 70) begin
            tick(m_ready, 16'(hist.size() + 1));
            budget++;
            checks++;
            if ({x_valid, frame_start, frame_last} !== {e_valid, e_fs, e_fl} || (e_valid && {tap_idx, x} !== {e_tap, e_x})) begin
                errors++;
                $display("FAIL wrap_stream cyc=%0d got v=%b tap=%0d x=%h exp v=%b tap=%0d x=%h",
                         cyc, x_valid, tap_idx, x, e_valid, e_tap, e_x);
            end
        end
        checks++;
        if (hist.size() != 65) begin
            errors++;
            $display("FAIL wrap_accepts got %0d exp 65", hist.size());
        end
        for (int i = 0; i < TAPS + 2; i++) begin
            tick(1'b0, 16'h0);
            if (x_valid === 1'b1 && tap_idx === 6'd63) last63 = x;
            checks++;
            if ({x_valid, frame_start, frame_last} !== {e_valid, e_fs, e_fl} || (e_valid && {tap_idx, x} !== {e_tap, e_x})) begin
                errors++;
                $display("FAIL wrap_last_frame cyc=%0d got v=%b tap=%0d x=%h exp v=%b tap=%0d x=%h",
                         cyc, x_valid, tap_idx, x, e_valid, e_tap, e_x);
            end
        end
        checks++;
        if (last63 !== 16'h0002) begin
            errors++;
            $display("FAIL wrap_tap63 got %h exp 0002", last63);
        end
    endtask

    task automatic test_back_to_back();
        int frames = 0;
        logic [15:0] f66_tap63 = 16'hDEAD;
        do_reset();
        for (int i = 0; i < 66 * TAPS + 4; i++) begin
            tick(1'b1, 16'h0100 + 16'(hist.size()));
            if (x_valid === 1'b1 && frame_start === 1'b1) frames++;
            if (frames == 66 && x_valid === 1'b1 && tap_idx === 6'd63) f66_tap63 = x;
            checks++;
            if ({x_valid, frame_start, frame_last} !== {e_valid, e_fs, e_fl} || (e_valid && {tap_idx, x} !== {e_tap, e_x})) begin
                errors++;
                $display("FAIL b2b_stream cyc=%0d got v=%b tap=%0d x=%h exp v=%b tap=%0d x=%h",
                         cyc, x_valid, tap_idx, x, e_valid, e_tap, e_x);
            end
            checks++;
            if ({din_ready, busy, overrun} !== {m_ready, m_busy, m_over}) begin
                errors++;
                $display("FAIL b2b_ctrl cyc=%0d got rdy=%b busy=%b ov=%b exp rdy=%b busy=%b ov=%b",
                         cyc, din_ready, busy, overrun, m_ready, m_busy, m_over);
            end
        end
        checks++;
        if (f66_tap63 !== 16'h0102) begin
            errors++;
            $display("FAIL b2b_rbw_tap63 got %h exp 0102", f66_tap63);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] v;
        int budget = 0;
        bit seen_beef = 0;
        do_reset();
        v = 16'($urandom());
        if (v == 16'hBEEF) v = 16'h0;
        tick(1'b1, v);
        while (cyc - a_cyc != 10 && budget < 100) begin
            tick(1'b0, 16'h0);
            budget++;
        end
        checks++;
        if (overrun !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pre got ov=%b rdy=%b exp ov=0 rdy=0", overrun, din_ready);
        end
        for (int i = 0; i < 2 * TAPS; i++) begin
            if (i == 0) tick(1'b1, 16'hBEEF);
            else if (i == TAPS) tick(m_ready, 16'h4321);
            else tick(1'b0, 16'h0);
            if (x_valid === 1'b1 && x === 16'hBEEF) seen_beef = 1;
            checks++;
            if ({x_valid, frame_start, frame_last} !== {e_valid, e_fs, e_fl} || (e_valid && {tap_idx, x} !== {e_tap, e_x})) begin
                errors++;
                $display("FAIL ovr_stream cyc=%0d got v=%b tap=%0d x=%h exp v=%b tap=%0d x=%h",
                         cyc, x_valid, tap_idx, x, e_valid, e_tap, e_x);
            end
            checks++;
            if (overrun !== 1'b1) begin
                errors++;
                $display("FAIL ovr_sticky cyc=%0d got %b exp 1", cyc, overrun);
            end
        end
        checks++;
        if (seen_beef) begin
            errors++;
            $display("FAIL ovr_dropped got BEEF on x exp never");
        end
    endtask

    task automatic test_reset_midframe();
        int budget = 0;
        do_reset();
        tick(1'b1, 16'($urandom()));
        tick(1'b1, 16'h5555);
        while (!(e_valid && e_tap == 6'd30) && budget < 100) begin
            tick(1'b0, 16'h0);
            budget++;
        end
        checks++;
        if (tap_idx !== 6'd30 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got tap=%0d ov=%b exp tap=30 ov=1", tap_idx, overrun);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (x_valid !== 1'b0 || x !== 16'h0 || overrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got v=%b x=%h ov=%b busy=%b exp 0 0000 0 0", x_valid, x, overrun, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        tick(1'b1, 16'h7FFF);
        for (int i = 0; i < TAPS + 2; i++) begin
            tick(1'b0, 16'h0);
            checks++;
            if ({x_valid, frame_start, frame_last} !== {e_valid, e_fs, e_fl} || (e_valid && {tap_idx, x} !== {e_tap, e_x})) begin
                errors++;
                $display("FAIL midrst_frame cyc=%0d got v=%b tap=%0d x=%h exp v=%b tap=%0d x=%h",
                         cyc, x_valid, tap_idx, x, e_valid, e_tap, e_x);
            end
            if (i == 0) begin
                checks++;
                if (x !== 16'h7FFF || tap_idx !== 6'd0) begin
                    errors++;
                    $display("FAIL midrst_tap0 got x=%h tap=%0d exp 7FFF 0", x, tap_idx);
                end
            end
        end
    endtask

    task automatic test_sign();
        logic [15:0] t0 = 16'h0, t1 = 16'h0;
        int budget = 0;
        do_reset();
        tick(1'b1, 16'h8000);
        while (!m_ready && budget < 100) begin
            tick(1'b0, 16'h0);
            budget++;
        end
        tick(1'b1, 16'hFFFF);
        for (int i = 0; i < TAPS + 2; i++) begin
            tick(1'b0, 16'h0);
            if (x_valid === 1'b1 && tap_idx === 6'd0) t0 = x;
            if (x_valid === 1'b1 && tap_idx === 6'd1) t1 = x;
            checks++;
            if ({x_valid, frame_start, frame_last} !== {e_valid, e_fs, e_fl} || (e_valid && {tap_idx, x} !== {e_tap, e_x})) begin
                errors++;
                $display("FAIL sign_stream cyc=%0d got v=%b tap=%0d x=%h exp v=%b tap=%0d x=%h",
                         cyc, x_valid, tap_idx, x, e_valid, e_tap, e_x);
            end
        end
        checks++;
        if (t0 !== 16'hFFFF || t1 !== 16'h8000) begin
            errors++;
            $display("FAIL sign_taps got t0=%h t1=%h exp FFFF 8000", t0, t1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 40) == 0, 16'($urandom()));
            checks++;
            if ({x_valid, frame_start, frame_last} !== {e_valid, e_fs, e_fl} || (e_valid && {tap_idx, x} !== {e_tap, e_x})) begin
                errors++;
                $display("FAIL rand_stream cyc=%0d got v=%b tap=%0d x=%h exp v=%b tap=%0d x=%h",
                         cyc, x_valid, tap_idx, x, e_valid, e_tap, e_x);
            end
            checks++;
            if ({din_ready, busy, overrun} !== {m_ready, m_busy, m_over}) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d got rdy=%b busy=%b ov=%b exp rdy=%b busy=%b ov=%b",
                         cyc, din_ready, busy, overrun, m_ready, m_busy, m_over);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_overrun();
        test_reset_midframe();
        test_sign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
